lcd_timing_gen: RTL and testbench

Parametrised LCD/RGB-panel timing generator for pixel-clocked parallel displays. Produces horizontal/vertical counters, configurable-polarity HSYNC/VSYNC, data-enable, frame/line start strobes, and a programmable sub-image window with window-relative coordinates. It sits between the pixel clock domain and the pixel source (pattern generator, framebuffer reader), replacing fixed-geometry timing logic so one block serves every panel the team supports.

---
 rtl/lcd_timing_pkg.sv | 55 +++++
 rtl/lcd_timing_if.sv | 43 ++++
 rtl/lcd_axis_counter.sv | 80 ++++++++
 rtl/lcd_timing_gen.sv | 116 +++++++++++
 tb/tb_lcd_timing_gen.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Shared definitions for the LCD timing generator: controller state
//   encoding, sync polarity encodings, standard panel geometries and the
//   elaboration-time geometry check used by every axis counter.
package lcd_timing_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lcd_state_t;

   // Sync polarity: the level driven while the pulse is active.
   localparam bit POL_ACTIVE_LOW  = 1'b0;
   localparam bit POL_ACTIVE_HIGH = 1'b1;

   // 480x272 panel (4.3" class).
   localparam int P480_H_ACTIVE = 480;
   localparam int P480_H_FP     = 8;
   localparam int P480_H_PULSE  = 4;
   localparam int P480_H_BP     = 43;
   localparam int P480_V_ACTIVE = 272;
   localparam int P480_V_FP     = 8;
   localparam int P480_V_PULSE  = 4;
   localparam int P480_V_BP     = 12;

   // 800x480 panel (7" class).
   localparam int P800_H_ACTIVE = 800;
   localparam int P800_H_FP     = 40;
   localparam int P800_H_PULSE  = 48;
   localparam int P800_H_BP     = 88;
   localparam int P800_V_ACTIVE = 480;
   localparam int P800_V_FP     = 13;
   localparam int P800_V_PULSE  = 3;
   localparam int P800_V_BP     = 32;

   function automatic int axis_total(input int active, input int fp,
                                     input int pulse, input int bp);
      return active + fp + pulse + bp;
   endfunction

   // True when one axis geometry is usable: non-empty active and pulse
   // regions, total fits in a cnt_w-bit counter, window inside active area.
   function automatic bit axis_ok(input int active, input int fp,
                                  input int pulse, input int bp,
                                  input int win0, input int winlen,
                                  input int cnt_w);
      longint lim;
      lim = longint'(1) << cnt_w;
      return (active > 0) && (pulse > 0) && (fp >= 0) && (bp >= 0) &&
             (win0 >= 0) && (winlen >= 0) &&
             (longint'(axis_total(active, fp, pulse, bp)) <= lim) &&
             (win0 + winlen <= active);
   endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// lcd_timing_if
//   Bundle between the timing generator (master) and the pixel source
//   (slave).
//   en                     : slave -> master, run enable
//   x, y                   : current pixel column / line
//   hsync, vsync           : syncs, panel polarity already applied
//   den                    : data enable, pixel is in the visible area
//   line_start/frame_start : one-cycle strobes at x==0 / (0,0)
//   win_en, wx, wy         : sub-window flag and window-relative coordinates
//   state                  : controller state, for observation only
// Handshake: there is no backpressure. Every output of a cycle describes
// the same pixel; the source must present data for that pixel whenever den
// is high. en is level-sensitive and acts on the next pixel_clk edge.
interface lcd_timing_if
   import lcd_timing_pkg::*;
#(
   parameter int CNT_W = 16
) ();
   logic             en;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             hsync;
   logic             vsync;
   logic             den;
   logic             line_start;
   logic             frame_start;
   logic             win_en;
   logic [CNT_W-1:0] wx;
   logic [CNT_W-1:0] wy;
   lcd_state_t       state;

   modport master (
      input  en,
      output x, y, hsync, vsync, den, line_start, frame_start,
             win_en, wx, wy, state
   );

   modport slave (
      output en,
      input  x, y, hsync, vsync, den, line_start, frame_start,
             win_en, wx, wy, state
   );
endinterface

// File: rtl/lcd_axis_counter.sv
// lcd_axis_counter
//   One timing axis: a counter over ACTIVE+FP+PULSE+BP positions plus the
//   region decodes for that axis. All decodes are taken from the value the
//   counter will hold after this edge (cnt_nxt), so the parent can register
//   them alongside the coordinate with no skew.
//   clk, rst : clock, synchronous active-low reset
//   step     : advance by one (wraps to 0 after the last position)
//   clear    : force to 0, overrides step
//   cnt_nxt  : counter value after this edge
//   wrap     : stepping from the last position this cycle
//   active   : cnt_nxt inside the active region
//   pulse    : cnt_nxt inside the sync pulse
//   in_win   : cnt_nxt inside [WIN0, WIN0+WINLEN)
//   rel      : cnt_nxt - WIN0 when in_win, else 0
module lcd_axis_counter
   import lcd_timing_pkg::*;
#(
   parameter int ACTIVE = 480,
   parameter int FP     = 8,
   parameter int PULSE  = 4,
   parameter int BP     = 43,
   parameter int WIN0   = 112,
   parameter int WINLEN = 256,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             wrap,
   output logic             active,
   output logic             pulse,
   output logic             in_win,
   output logic [CNT_W-1:0] rel
);
   localparam int TOTAL = axis_total(ACTIVE, FP, PULSE, BP);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] WIN0_N = CNT_W'(WIN0);
   // Region bounds carry one extra bit: an end bound may equal 2^CNT_W.
   localparam logic [CNT_W:0] ACT_END   = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0] PULSE_BEG = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0] PULSE_END = (CNT_W+1)'(ACTIVE + FP + PULSE);
   localparam logic [CNT_W:0] WIN_BEG   = (CNT_W+1)'(WIN0);
   localparam logic [CNT_W:0] WIN_END   = (CNT_W+1)'(WIN0 + WINLEN);

   if (!axis_ok(ACTIVE, FP, PULSE, BP, WIN0, WINLEN, CNT_W)) begin : g_bad_geometry
      $error("lcd_axis_counter: invalid axis geometry");
   end

   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_ext;

   assign wrap = step && (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (clear) begin
         cnt_nxt = '0;
      end else if (wrap) begin
         cnt_nxt = '0;
      end else if (step) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   assign cnt_ext = {1'b0, cnt_nxt};
   assign active  = cnt_ext < ACT_END;
   assign pulse   = (cnt_ext >= PULSE_BEG) && (cnt_ext < PULSE_END);
   assign in_win  = (cnt_ext >= WIN_BEG) && (cnt_ext < WIN_END);
   assign rel     = in_win ? (cnt_nxt - WIN0_N) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   LCD/RGB panel timing generator. An IDLE/RUN controller gates two axis
//   counters (horizontal stepped every cycle, vertical stepped on
//   horizontal wrap); every bus output is a register holding the decode of
//   the counters' next values, so all outputs of a cycle describe one pixel.
//   pixel_clk : pixel clock, rising edge
//   rst       : synchronous active-low reset
//   bus       : lcd_timing_if master side (en in; coordinates, syncs,
//               data enable, strobes, window outputs, state out)
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = P480_H_ACTIVE,
   parameter int H_FP     = P480_H_FP,
   parameter int H_PULSE  = P480_H_PULSE,
   parameter int H_BP     = P480_H_BP,
   parameter int V_ACTIVE = P480_V_ACTIVE,
   parameter int V_FP     = P480_V_FP,
   parameter int V_PULSE  = P480_V_PULSE,
   parameter int V_BP     = P480_V_BP,
   parameter bit HS_POL   = POL_ACTIVE_LOW,
   parameter bit VS_POL   = POL_ACTIVE_LOW,
   parameter int WIN_X0   = 112,
   parameter int WIN_W    = 256,
   parameter int WIN_Y0   = 8,
   parameter int WIN_H    = 256,
   parameter int CNT_W    = 16
) (
   input  logic         pixel_clk,
   input  logic         rst,
   lcd_timing_if.master bus
);
   lcd_state_t       state;
   lcd_state_t       state_nxt;
   logic             run_nxt;
   logic             clear;
   logic             h_step;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             h_wrap, v_wrap;
   logic             h_act, v_act;
   logic             h_pulse, v_pulse;
   logic             h_win, v_win;
   logic [CNT_W-1:0] h_rel, v_rel;

   always_ff @(posedge pixel_clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = 1'b0;
      case (state)
         ST_IDLE: if (bus.en)  state_nxt = ST_RUN;
         ST_RUN:  if (!bus.en) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      run_nxt = rst && (state_nxt == ST_RUN);
   end

   // Counters sit at the origin in IDLE and on the first RUN cycle, so the
   // first running pixel is (0,0).
   assign clear  = (state != ST_RUN) || !run_nxt;
   assign h_step = (state == ST_RUN);

   lcd_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .PULSE (H_PULSE), .BP (H_BP),
      .WIN0 (WIN_X0), .WINLEN (WIN_W), .CNT_W (CNT_W)
   ) u_h (
      .clk (pixel_clk), .rst (rst), .step (h_step), .clear (clear),
      .cnt_nxt (h_nxt), .wrap (h_wrap), .active (h_act), .pulse (h_pulse),
      .in_win (h_win), .rel (h_rel)
   );

   lcd_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .PULSE (V_PULSE), .BP (V_BP),
      .WIN0 (WIN_Y0), .WINLEN (WIN_H), .CNT_W (CNT_W)
   ) u_v (
      .clk (pixel_clk), .rst (rst), .step (h_wrap), .clear (clear),
      .cnt_nxt (v_nxt), .wrap (v_wrap), .active (v_act), .pulse (v_pulse),
      .in_win (v_win), .rel (v_rel)
   );

   assign bus.state = state;

   // A line begins on entry to RUN or when x wraps; a frame begins on entry
   // to RUN or when y wraps (which only happens together with an x wrap).
   always_ff @(posedge pixel_clk) begin
      if (!rst || !run_nxt) begin
         bus.x           <= '0;
         bus.y           <= '0;
         bus.hsync       <= ~HS_POL;
         bus.vsync       <= ~VS_POL;
         bus.den         <= 1'b0;
         bus.line_start  <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.win_en      <= 1'b0;
         bus.wx          <= '0;
         bus.wy          <= '0;
      end else begin
         bus.x           <= h_nxt;
         bus.y           <= v_nxt;
         bus.hsync       <= h_pulse ? HS_POL : ~HS_POL;
         bus.vsync       <= v_pulse ? VS_POL : ~VS_POL;
         bus.den         <= h_act && v_act;
         bus.line_start  <= (state != ST_RUN) || h_wrap;
         bus.frame_start <= (state != ST_RUN) || v_wrap;
         bus.win_en      <= h_win && v_win;
         bus.wx          <= (h_win && v_win) ? h_rel : '0;
         bus.wy          <= (h_win && v_win) ? v_rel : '0;
      end
   end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
//   Bench for lcd_timing_gen. Two instances: a small geometry (25x17
//   totals, active-low syncs) that completes whole frames quickly, and an
//   800-wide active-high instance. A per-cycle reference model derives every
//   output from the elapsed RUN cycle count with plain div/mod arithmetic.
module tb_lcd_timing_gen;
   import lcd_timing_pkg::*;

   localparam int A_HA = 16, A_HFP = 2, A_HP = 3, A_HBP = 4;
   localparam int A_VA = 10, A_VFP = 2, A_VP = 2, A_VBP = 3;
   localparam int A_HT = A_HA + A_HFP + A_HP + A_HBP;
   localparam int A_VT = A_VA + A_VFP + A_VP + A_VBP;

   typedef struct {
      int ha, hfp, hp, hbp, va, vfp, vp, vbp;
      bit hpol, vpol;
      int wx0, ww, wy0, wh;
   } geom_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic        hs;
      logic        vs;
      logic        den;
      logic        ls;
      logic        fs;
      logic        we;
      logic [15:0] wx;
      logic [15:0] wy;
   } obs_t;

   typedef struct {
      int   x, y;
      logic den, hs, vs, we, ls, fs;
      int   wx, wy;
   } vec_t;

   logic pixel_clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   geom_t g [2];
   bit    run_m [2];
   int    t_m [2];
   obs_t  obs [2];

   lcd_timing_if #(.CNT_W(16)) if_a ();
   lcd_timing_if #(.CNT_W(16)) if_b ();

   lcd_timing_gen #(
      .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_PULSE(A_HP), .H_BP(A_HBP),
      .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_PULSE(A_VP), .V_BP(A_VBP),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .WIN_X0(3), .WIN_W(8), .WIN_Y0(2), .WIN_H(5), .CNT_W(16)
   ) dut_a (
      .pixel_clk (pixel_clk), .rst (rst), .bus (if_a)
   );

   lcd_timing_gen #(
      .H_ACTIVE(P800_H_ACTIVE), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(16)
   ) dut_b (
      .pixel_clk (pixel_clk), .rst (rst), .bus (if_b)
   );

   assign obs[0] = {if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.den,
                    if_a.line_start, if_a.frame_start, if_a.win_en,
                    if_a.wx, if_a.wy};
   assign obs[1] = {if_b.x, if_b.y, if_b.hsync, if_b.vsync, if_b.den,
                    if_b.line_start, if_b.frame_start, if_b.win_en,
                    if_b.wx, if_b.wy};

   // clock
   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   function automatic string fmt(input obs_t o);
      return $sformatf("x=%0d y=%0d hs=%0b vs=%0b den=%0b ls=%0b fs=%0b we=%0b wx=%0d wy=%0d",
                       o.x, o.y, o.hs, o.vs, o.den, o.ls, o.fs, o.we, o.wx, o.wy);
   endfunction

   // Reference: output for the t-th cycle since RUN was entered.
   function automatic obs_t model(input geom_t gg, input bit run, input int t);
      obs_t o;
      int   ht, vt, px, py, hb, vb;
      bit   inw;
      o = '0;
      o.hs = ~gg.hpol;
      o.vs = ~gg.vpol;
      if (run) begin
         ht = gg.ha + gg.hfp + gg.hp + gg.hbp;
         vt = gg.va + gg.vfp + gg.vp + gg.vbp;
         px = t % ht;
         py = (t / ht) % vt;
         hb = gg.ha + gg.hfp;
         vb = gg.va + gg.vfp;
         o.x   = 16'(px);
         o.y   = 16'(py);
         o.den = (px < gg.ha) && (py < gg.va);
         o.hs  = (px >= hb && px < hb + gg.hp) ? gg.hpol : ~gg.hpol;
         o.vs  = (py >= vb && py < vb + gg.vp) ? gg.vpol : ~gg.vpol;
         o.ls  = (px == 0);
         o.fs  = (px == 0) && (py == 0);
         inw   = (px >= gg.wx0) && (px < gg.wx0 + gg.ww) &&
                 (py >= gg.wy0) && (py < gg.wy0 + gg.wh);
         o.we  = inw;
         o.wx  = inw ? 16'(px - gg.wx0) : 16'd0;
         o.wy  = inw ? 16'(py - gg.wy0) : 16'd0;
      end
      return o;
   endfunction

   task automatic check_val(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
      end
   endtask

   // driver: one pixel clock; advance the model from the sampled inputs,
   // then compare both instances #1 after the edge
   task automatic tick();
      bit en_d;
      @(posedge pixel_clk);
      for (int d = 0; d < 2; d++) begin
         en_d = (d == 0) ? if_a.en : if_b.en;
         if (!rst || !en_d) begin
            run_m[d] = 1'b0;
            t_m[d]   = 0;
         end else if (!run_m[d]) begin
            run_m[d] = 1'b1;
            t_m[d]   = 0;
         end else begin
            t_m[d]++;
         end
      end
      #1;
      check_obs("model_a", obs[0], model(g[0], run_m[0], t_m[0]));
      check_obs("model_b", obs[1], model(g[1], run_m[1], t_m[1]));
   endtask

   // restart instance A and stop when it presents pixel (px,py)
   task automatic goto_a(input int px, input int py);
      if_a.en = 1'b0;
      tick();
      if_a.en = 1'b1;
      repeat (py * A_HT + px + 1) tick();
   endtask

   function automatic logic strobe(input int d, input bit frame);
      return frame ? obs[d].fs : obs[d].ls;
   endfunction

   // cycles between two consecutive strobes, bounded
   task automatic measure(input int d, input bit frame, input int exp_p,
                          input string name);
      int n;
      int budget;
      budget = 2 * exp_p + 10;
      n = 0;
      while (!strobe(d, frame) && n < budget) begin
         tick();
         n++;
      end
      if (!strobe(d, frame)) begin
         check_val({name, "_timeout"}, n, -1);
      end else begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!strobe(d, frame) && n < budget);
         check_val(name, n, exp_p);
      end
   endtask

   vec_t vecs [17];

   initial begin
      obs_t e;

      g[0] = '{A_HA, A_HFP, A_HP, A_HBP, A_VA, A_VFP, A_VP, A_VBP,
               1'b0, 1'b0, 3, 8, 2, 5};
      g[1] = '{P800_H_ACTIVE, P480_H_FP, P480_H_PULSE, P480_H_BP,
               P480_V_ACTIVE, P480_V_FP, P480_V_PULSE, P480_V_BP,
               1'b1, 1'b1, 112, 256, 8, 256};
      run_m[0] = 1'b0; run_m[1] = 1'b0;
      t_m[0] = 0; t_m[1] = 0;

      //           x   y  den hs vs we ls fs wx wy
      vecs[0]  = '{ 0,  0, 1, 1, 1, 0, 1, 1, 0, 0};
      vecs[1]  = '{15,  0, 1, 1, 1, 0, 0, 0, 0, 0};
      vecs[2]  = '{16,  0, 0, 1, 1, 0, 0, 0, 0, 0};
      vecs[3]  = '{17,  0, 0, 1, 1, 0, 0, 0, 0, 0};
      vecs[4]  = '{18,  0, 0, 0, 1, 0, 0, 0, 0, 0};
      vecs[5]  = '{20,  0, 0, 0, 1, 0, 0, 0, 0, 0};
      vecs[6]  = '{21,  0, 0, 1, 1, 0, 0, 0, 0, 0};
      vecs[7]  = '{ 3,  2, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[8]  = '{10,  6, 1, 1, 1, 1, 0, 0, 7, 4};
      vecs[9]  = '{11,  2, 1, 1, 1, 0, 0, 0, 0, 0};
      vecs[10] = '{ 2,  2, 1, 1, 1, 0, 0, 0, 0, 0};
      vecs[11] = '{ 3,  7, 1, 1, 1, 0, 0, 0, 0, 0};
      vecs[12] = '{ 5, 11, 0, 1, 1, 0, 0, 0, 0, 0};
      vecs[13] = '{ 0, 12, 0, 1, 0, 0, 1, 0, 0, 0};
      vecs[14] = '{19, 13, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[15] = '{ 0, 14, 0, 1, 1, 0, 1, 0, 0, 0};
      vecs[16] = '{24, 16, 0, 1, 1, 0, 0, 0, 0, 0};

      // reset state
      rst = 1'b0;
      if_a.en = 1'b0;
      if_b.en = 1'b0;
      tick();
      tick();
      check_val("rst_state_a", int'(if_a.state), int'(ST_IDLE));
      check_val("rst_hs_a", int'(if_a.hsync), 1);
      check_val("rst_vs_a", int'(if_a.vsync), 1);
      check_val("rst_hs_b", int'(if_b.hsync), 0);
      check_val("rst_vs_b", int'(if_b.vsync), 0);
      check_val("rst_den_a", int'(if_a.den), 0);

      // en held high during reset must not start the generator
      if_a.en = 1'b1;
      tick();
      check_val("rst_over_en_den", int'(if_a.den), 0);
      check_val("rst_over_en_fs", int'(if_a.frame_start), 0);

      // first RUN cycle presents (0,0)
      rst = 1'b1;
      if_b.en = 1'b1;
      tick();
      check_val("first_fs_a", int'(if_a.frame_start), 1);
      check_val("first_ls_a", int'(if_a.line_start), 1);
      check_val("first_den_a", int'(if_a.den), 1);
      check_val("first_state_a", int'(if_a.state), int'(ST_RUN));
      check_val("first_fs_b", int'(if_b.frame_start), 1);

      // strobe periods
      measure(0, 1'b0, A_HT, "a_line_period");
      measure(0, 1'b1, A_HT * A_VT, "a_frame_period");
      measure(1, 1'b0, 855, "b_line_period");

      // table of pixels on instance A
      foreach (vecs[i]) begin
         goto_a(vecs[i].x, vecs[i].y);
         e    = '0;
         e.x  = 16'(vecs[i].x);
         e.y  = 16'(vecs[i].y);
         e.den = vecs[i].den; e.hs = vecs[i].hs; e.vs = vecs[i].vs;
         e.we = vecs[i].we;   e.ls = vecs[i].ls; e.fs = vecs[i].fs;
         e.wx = 16'(vecs[i].wx);
         e.wy = 16'(vecs[i].wy);
         check_obs($sformatf("vec%0d", i), obs[0], e);
      end

      // en dropped mid-frame, then raised again
      goto_a(7, 3);
      if_a.en = 1'b0;
      tick();
      check_val("drop_den", int'(if_a.den), 0);
      check_val("drop_hs", int'(if_a.hsync), 1);
      check_val("drop_x", int'(if_a.x), 0);
      if_a.en = 1'b1;
      tick();
      check_val("reraise_fs", int'(if_a.frame_start), 1);
      check_val("reraise_xy", int'({if_a.x, if_a.y}), 0);

      // active-high hsync on B, pulse at x 808..811
      if_b.en = 1'b0;
      tick();
      if_b.en = 1'b1;
      repeat (808) tick();
      check_val("b_x807", int'(if_b.x), 807);
      check_val("b_hs807", int'(if_b.hsync), 0);
      tick();
      check_val("b_hs808", int'(if_b.hsync), 1);
      repeat (3) tick();
      check_val("b_hs811", int'(if_b.hsync), 1);
      tick();
      check_val("b_hs812", int'(if_b.hsync), 0);

      // rst low mid-line on B
      if_b.en = 1'b0;
      tick();
      if_b.en = 1'b1;
      repeat (301) tick();
      check_val("b_x300", int'(if_b.x), 300);
      rst = 1'b0;
      tick();
      check_val("b_rst_x", int'(if_b.x), 0);
      check_val("b_rst_hs", int'(if_b.hsync), 0);
      check_val("b_rst_vs", int'(if_b.vsync), 0);
      check_val("b_rst_den", int'(if_b.den), 0);
      check_val("b_rst_state", int'(if_b.state), int'(ST_IDLE));
      rst = 1'b1;
      tick();
      check_val("b_restart_fs", int'(if_b.frame_start), 1);

      // random enable / reset activity, model-checked every cycle
      for (int i = 0; i < 5000; i++) begin
         if_a.en = ($urandom_range(0, 199) != 0);
         if_b.en = ($urandom_range(0, 199) != 0);
         rst     = ($urandom_range(0, 999) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
